// File: rtl/control_sequencer.sv
// Hardwired control sequencer for the single-bus datapath: fetch T0-T2, execute T3-T6.
// Optional single-step gating is enabled by defining CTRL_SINGLE_STEP_EN.
module control_sequencer #(
    parameter int OPW = 5,
    parameter int RSW = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           run,
    input  logic           mem_ready,
`ifdef CTRL_SINGLE_STEP_EN
    input  logic           step,
`endif
    input  logic [31:0]    ir,
    output logic           PCout,
    output logic           Zlowout,
    output logic           Zhighout,
    output logic           MDRout,
    output logic           MARin,
    output logic           Zin,
    output logic           PCin,
    output logic           MDRin,
    output logic           IRin,
    output logic           Yin,
    output logic           HIin,
    output logic           LOin,
    output logic           IncPC,
    output logic           Read,
    output logic           reg_out_en,
    output logic [RSW-1:0] reg_out_sel,
    output logic           reg_in_en,
    output logic [RSW-1:0] reg_in_sel,
    output logic [OPW-1:0] alu_instruction,
    output logic           illegal_op
);

    typedef enum logic [2:0] {StIdle, StT0, StT1, StT2, StT3, StT4, StT5, StT6} state_e;

    localparam logic [OPW-1:0] OpAdd  = OPW'(5'b00011);
    localparam logic [OPW-1:0] OpRol  = OPW'(5'b01011);
    localparam logic [OPW-1:0] OpMul  = OPW'(5'b01111);
    localparam logic [OPW-1:0] OpDiv  = OPW'(5'b10000);
    localparam logic [OPW-1:0] OpNeg  = OPW'(5'b10001);
    localparam logic [OPW-1:0] OpNot  = OPW'(5'b10010);

    state_e         r_state;
    logic [OPW-1:0] w_opcode;
    logic [RSW-1:0] w_ra, w_rb, w_rc;
    logic           w_binop, w_unop, w_muldiv, w_legal, w_go;
    logic           w_unused_ir;

    assign w_opcode    = ir[31 -: OPW];
    assign w_ra        = ir[31-OPW -: RSW];
    assign w_rb        = ir[31-OPW-RSW -: RSW];
    assign w_rc        = ir[31-OPW-2*RSW -: RSW];
    assign w_unused_ir = ^ir[31-OPW-3*RSW:0];

    // add..rol form a contiguous block; mul/div and the unary pair are handled separately.
    assign w_muldiv = (w_opcode == OpMul) || (w_opcode == OpDiv);
    assign w_unop   = (w_opcode == OpNeg) || (w_opcode == OpNot);
    assign w_binop  = ((w_opcode >= OpAdd) && (w_opcode <= OpRol)) || w_muldiv;
    assign w_legal  = w_binop || w_unop;

`ifdef CTRL_SINGLE_STEP_EN
    assign w_go = run && step;
`else
    assign w_go = run;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= StIdle;
        end else begin
            case (r_state)
                StIdle:  if (w_go) r_state <= StT0;
                StT0:    r_state <= StT1;
                StT1:    if (mem_ready) r_state <= StT2;
                StT2:    r_state <= StT3;
                StT3:    r_state <= w_legal ? StT4 : (w_go ? StT0 : StIdle);
                StT4:    r_state <= StT5;
                StT5:    r_state <= w_muldiv ? StT6 : (w_go ? StT0 : StIdle);
                StT6:    r_state <= w_go ? StT0 : StIdle;
                default: r_state <= StIdle;
            endcase
        end
    end

    always_comb begin
        PCout           = 1'b0;
        Zlowout         = 1'b0;
        Zhighout        = 1'b0;
        MDRout          = 1'b0;
        MARin           = 1'b0;
        Zin             = 1'b0;
        PCin            = 1'b0;
        MDRin           = 1'b0;
        IRin            = 1'b0;
        Yin             = 1'b0;
        HIin            = 1'b0;
        LOin            = 1'b0;
        IncPC           = 1'b0;
        Read            = 1'b0;
        reg_out_en      = 1'b0;
        reg_out_sel     = '0;
        reg_in_en       = 1'b0;
        reg_in_sel      = '0;
        alu_instruction = '0;
        illegal_op      = 1'b0;
        case (r_state)
            StT0: begin
                PCout = 1'b1;
                MARin = 1'b1;
                IncPC = 1'b1;
                Zin   = 1'b1;
            end
            StT1: begin
                Zlowout = 1'b1;
                PCin    = 1'b1;
                Read    = 1'b1;
                MDRin   = 1'b1;
            end
            StT2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            StT3: begin
                reg_out_en  = 1'b1;
                reg_out_sel = w_rb;
                Yin         = w_legal;
                illegal_op  = !w_legal;
            end
            StT4: begin
                reg_out_en      = 1'b1;
                reg_out_sel     = w_unop ? w_rb : w_rc;
                alu_instruction = w_opcode;
                Zin             = 1'b1;
            end
            StT5: begin
                Zlowout = 1'b1;
                if (w_muldiv) begin
                    LOin = 1'b1;
                end else begin
                    reg_in_en  = 1'b1;
                    reg_in_sel = w_ra;
                end
            end
            StT6: begin
                Zhighout = 1'b1;
                HIin     = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Table-driven checks of the control sequencer outputs, one record per clock cycle,
// plus a hand-written asynchronous reset sequence.
module tb_control_sequencer;

    logic        clk = 1'b0;
    logic        reset, run, mem_ready;
    logic [31:0] ir;
    logic        PCout, Zlowout, Zhighout, MDRout, MARin, Zin, PCin, MDRin;
    logic        IRin, Yin, HIin, LOin, IncPC, Read, reg_out_en, reg_in_en, illegal_op;
    logic [3:0]  reg_out_sel, reg_in_sel;
    logic [4:0]  alu_instruction;

    control_sequencer #(.OPW(5), .RSW(4)) dut (
        .clk(clk), .reset(reset), .run(run), .mem_ready(mem_ready),
`ifdef CTRL_SINGLE_STEP_EN
        .step(1'b1),
`endif
        .ir(ir), .PCout(PCout), .Zlowout(Zlowout), .Zhighout(Zhighout), .MDRout(MDRout),
        .MARin(MARin), .Zin(Zin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
        .HIin(HIin), .LOin(LOin), .IncPC(IncPC), .Read(Read), .reg_out_en(reg_out_en),
        .reg_out_sel(reg_out_sel), .reg_in_en(reg_in_en), .reg_in_sel(reg_in_sel),
        .alu_instruction(alu_instruction), .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    // Strobe bit positions in the 16-bit mask that leads the packed output word.
    localparam logic [15:0] S_PCOUT = 16'h8000, S_ZLOW = 16'h4000, S_ZHIGH = 16'h2000;
    localparam logic [15:0] S_MDROUT = 16'h1000, S_MARIN = 16'h0800, S_ZIN = 16'h0400;
    localparam logic [15:0] S_PCIN = 16'h0200, S_MDRIN = 16'h0100, S_IRIN = 16'h0080;
    localparam logic [15:0] S_YIN = 16'h0040, S_HIIN = 16'h0020, S_LOIN = 16'h0010;
    localparam logic [15:0] S_INCPC = 16'h0008, S_READ = 16'h0004, S_ROUT = 16'h0002;
    localparam logic [15:0] S_RIN = 16'h0001;

    localparam logic [31:0] IR_AND = 32'h2891_8000;
    localparam logic [31:0] IR_MUL = 32'h7822_8000;
    localparam logic [31:0] IR_NOT = 32'h9238_0000;
    localparam logic [31:0] IR_ILL = 32'hF800_0000;
    localparam logic [31:0] IR_ADD = 32'h1891_8000;

    typedef struct {
        string       name;
        logic        run;
        logic        mr;
        logic [31:0] ir;
        logic [29:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    function automatic logic [29:0] ex(input logic [15:0] s, input logic [3:0] osel,
                                       input logic [3:0] isel, input logic [4:0] alu,
                                       input logic ill);
        return {s, osel, isel, alu, ill};
    endfunction

    function automatic logic [29:0] got();
        return {PCout, Zlowout, Zhighout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin, HIin,
                LOin, IncPC, Read, reg_out_en, reg_in_en, reg_out_sel, reg_in_sel,
                alu_instruction, illegal_op};
    endfunction

    task automatic check(input string name, input logic [29:0] exp);
        logic [29:0] g;
        g = got();
        n_checks++;
        if (g === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", name, g, exp);
    endtask

    task automatic add(input string name, input logic r, input logic m, input logic [31:0] i,
                       input logic [29:0] e);
        vec_t v;
        v.name = name; v.run = r; v.mr = m; v.ir = i; v.exp = e;
        vecs.push_back(v);
    endtask

    initial begin
        logic [29:0] e_t0, e_t1, e_t2;
        e_t0 = ex(S_PCOUT | S_MARIN | S_INCPC | S_ZIN, 0, 0, 0, 0);
        e_t1 = ex(S_ZLOW | S_PCIN | S_READ | S_MDRIN, 0, 0, 0, 0);
        e_t2 = ex(S_MDROUT | S_IRIN, 0, 0, 0, 0);

        add("and_idle", 1, 1, 0,      '0);
        add("and_t0",   1, 1, 0,      e_t0);
        add("and_t1",   1, 1, 0,      e_t1);
        add("and_t2",   1, 1, 0,      e_t2);
        add("and_t3",   1, 1, IR_AND, ex(S_ROUT | S_YIN, 2, 0, 0, 0));
        add("and_t4",   1, 1, IR_AND, ex(S_ROUT | S_ZIN, 3, 0, 5'b00101, 0));
        add("and_t5",   1, 1, IR_AND, ex(S_ZLOW | S_RIN, 0, 1, 0, 0));
        add("mul_t0",   1, 1, IR_AND, e_t0);
        add("mul_t1",   1, 1, IR_AND, e_t1);
        add("mul_t2",   1, 1, IR_AND, e_t2);
        add("mul_t3",   1, 1, IR_MUL, ex(S_ROUT | S_YIN, 4, 0, 0, 0));
        add("mul_t4",   1, 1, IR_MUL, ex(S_ROUT | S_ZIN, 5, 0, 5'b01111, 0));
        add("mul_t5",   1, 1, IR_MUL, ex(S_ZLOW | S_LOIN, 0, 0, 0, 0));
        add("mul_t6",   1, 1, IR_MUL, ex(S_ZHIGH | S_HIIN, 0, 0, 0, 0));
        add("not_t0",   1, 1, IR_MUL, e_t0);
        add("not_t1",   1, 1, IR_MUL, e_t1);
        add("not_t2",   1, 1, IR_MUL, e_t2);
        add("not_t3",   1, 1, IR_NOT, ex(S_ROUT | S_YIN, 7, 0, 0, 0));
        add("not_t4",   1, 1, IR_NOT, ex(S_ROUT | S_ZIN, 7, 0, 5'b10010, 0));
        add("not_t5",   1, 1, IR_NOT, ex(S_ZLOW | S_RIN, 0, 4, 0, 0));
        add("wait_t0",  1, 1, IR_NOT, e_t0);
        add("wait_t1a", 1, 0, IR_NOT, e_t1);
        add("wait_t1b", 1, 0, IR_NOT, e_t1);
        add("wait_t1c", 1, 0, IR_NOT, e_t1);
        add("wait_t1d", 1, 1, IR_NOT, e_t1);
        add("wait_t2",  1, 1, IR_NOT, e_t2);
        add("ill_t3",   1, 1, IR_ILL, ex(S_ROUT, 0, 0, 0, 1));
        add("ill_t0",   1, 1, IR_ILL, e_t0);
        add("park_t1",  0, 1, IR_ILL, e_t1);
        add("park_t2",  0, 1, IR_ILL, e_t2);
        add("park_t3",  0, 1, IR_AND, ex(S_ROUT | S_YIN, 2, 0, 0, 0));
        add("park_t4",  0, 1, IR_AND, ex(S_ROUT | S_ZIN, 3, 0, 5'b00101, 0));
        add("park_t5",  0, 1, IR_AND, ex(S_ZLOW | S_RIN, 0, 1, 0, 0));
        add("park_id0", 0, 1, IR_AND, '0);
        add("park_id1", 0, 1, IR_AND, '0);

        reset = 1'b1; run = 1'b0; mem_ready = 1'b0; ir = '0;
        @(negedge clk);
        @(negedge clk);
        #1 check("reset_state", '0);
        reset = 1'b0;

        foreach (vecs[i]) begin
            @(negedge clk);
            run = vecs[i].run; mem_ready = vecs[i].mr; ir = vecs[i].ir;
            #1 check(vecs[i].name, vecs[i].exp);
        end

        // Add instruction, then async reset while in T4.
        @(negedge clk);
        run = 1'b1; mem_ready = 1'b1; ir = IR_ADD;
        repeat (5) @(negedge clk);
        #1 check("add_t4", ex(S_ROUT | S_ZIN, 3, 0, 5'b00011, 0));
        reset = 1'b1;
        run   = 1'b0;
        #1 check("reset_async", '0);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1 check("idle_after_reset", '0);
        end
        run = 1'b1;
        @(negedge clk);
        #1 check("restart_t0", ex(S_PCOUT | S_MARIN | S_INCPC | S_ZIN, 0, 0, 0, 0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
